float_multi_seq: RTL and testbench
==================================

# float_multi_seq

Sequential, parametrised IEEE-754-style floating-point multiplier, successor to the combinational `float_multi`. It generalises the format to any exponent and fraction width and computes the significand product with an iterative shift-add datapath. Operands and results move through valid/ready handshakes. It is intended for clocked datapaths where a full combinational multiplier is too large or too slow.

## Interface
- `EXP_W`, default 5: exponent field width, minimum 3; bias = 2^(EXP_W-1)-1.
- `FRA_W`, default 10: fraction field width, minimum 2.
- Word width `W` = 1+EXP_W+FRA_W; layout {sign, exp, fra}.

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `num1` in W: operand A.
- `num2` in W: operand B.
- `valid_i` in 1: operands present.
- `ready_o` out 1: block idle, accepts operands.
- `result` out W: product.
- `valid_o` out 1: result and flags valid.
- `ready_i` in 1: consumer takes result.
- `overflow` out 1: finite operands, product too large, result is ±inf.
- `zero` out 1: result magnitude is zero.
- `nan` out 1: result is NaN.
- `precision_lost` out 1: nonzero bits discarded by truncation.
- `underflow` out 1: result is subnormal or zero, and `precision_lost` is set.

## Operation
- **States:** IDLE, MUL, NORM, DONE.
- **`ready_o`:** `ready_o` = (state==IDLE) && !rst.
- **Accept:** operands are accepted on the edge where `valid_i && ready_o`. `num1`/`num2` are latched and go to MUL with counter=0. Later changes on `num1`/`num2` are ignored.
- **Unpack:** a normal operand has significand {1,fra} and exponent exp. A subnormal operand (exp==0) has significand {0,fra} and effective exponent 1.
- **MUL:**
  - Runs exactly FRA_W+1 cycles.
  - Each cycle examines one multiplier bit, LSB first. It conditionally adds the shifted multiplicand into a 2*(FRA_W+1)-bit accumulator.
  - Goes to NORM when counter==FRA_W.
- **Exponent:** exponent sum eA+eB-bias is computed in a signed EXP_W+2-bit register.
- **NORM (one cycle):**
  - Leading-one detect on the product, then shift to normalise.
  - If the biased exponent ≤ 0, shift right into subnormal range. All shifted-out bits are ORed into sticky.
  - Rounding is truncation toward zero. `precision_lost` = sticky.
  - If the biased exponent ≥ 2^EXP_W-1, the result is ±inf and `overflow`=1.
- **Sign:** sign = signA ^ signB for every non-NaN result, zero included.
- **Special cases** (no shortcut; these still pass through MUL and NORM):
  - NaN operand, or inf×0: result = canonical NaN {0, all-ones exp, fra MSB=1, rest 0}. `nan`=1, all other flags 0.
  - inf × nonzero finite, or inf×inf: ±inf, all flags 0.
  - An exact zero operand with a finite other operand: ±0, `zero`=1, other flags 0.
- **DONE:** `result` and flags are held stable while `valid_o`=1. They change only on reset or on the next completed operation.
- **Return to IDLE:** on the edge with `valid_o && ready_i`, go to IDLE. `valid_o` drops that edge. An accept cannot occur in the same cycle.

## Timing
- **Reset:** all outputs 0 (`result`=0, `valid_o`=0, all flags 0) and state=IDLE.
  - `ready_o`=0 while `rst` is high, and 1 the first cycle after `rst` falls.
- **Latency:** with the accept at edge 0, `valid_o` rises at edge FRA_W+2 (edge 12 for the defaults).
  - Latency is constant for all operand classes.
- **Throughput:** one operation per FRA_W+3 cycles minimum, achieved when `ready_i` is held high.
- **Reset mid-operation** (MUL, NORM or DONE): the operation is aborted and no result is ever presented.
- **Backpressure:** `ready_i` low in DONE holds everything indefinitely. `valid_i` is ignored outside IDLE.

## Test plan
- Exact normal: 0x3E00 × 0x4000 → 0x4200, flags 0. 0xC000 × 0x3800 → 0xBC00, flags 0. `valid_o` exactly 12 cycles after accept.
- Underflow to subnormal: 0x1234 × 0x9876 → 0x801B, `precision_lost`=1, `underflow`=1. Then 0x0001 × 0x0001 → 0x0000, `zero`=1, `precision_lost`=1, `underflow`=1.
- Subnormal input normalised: 0x0200 × 0x5800 → 0x1C00, flags 0.
- Specials:
  - 0x7BFF × 0x4000 → 0x7C00, `overflow`=1.
  - 0x7C00 × 0x0000 → 0x7E00, `nan`=1.
  - 0xFC00 × 0x4000 → 0xFC00, flags 0.
  - 0x4A00 × 0x8000 → 0x8000, `zero`=1.
- Handshake:
  - Hold `ready_i`=0 for 20 cycles in DONE: result and flags stable, `ready_o`=0, and a toggling `valid_i`/`num1` has no effect.
  - Release `ready_i`: IDLE next cycle. Back-to-back ops every 13 cycles.
- Reset: assert `rst` at MUL cycle 5 → all outputs 0 next edge, no `valid_o` afterwards. A fresh 0x3C00 × 0x3C00 then gives 0x3C00.
- Parameter sweep: EXP_W=8, FRA_W=23. 0x3FC00000 × 0x40000000 → 0x40400000, `valid_o` at edge 25.

Source files
------------

// File: rtl/float_multi_seq.sv
// Sequential floating-point multiplier: shift-add significand product, then a single
// normalise/truncate cycle. Operands and results move through valid/ready handshakes.
module float_multi_seq #(
  parameter int unsigned EXP_W = 5,
  parameter int unsigned FRA_W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [EXP_W+FRA_W:0] num1,
  input  logic [EXP_W+FRA_W:0] num2,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [EXP_W+FRA_W:0] result,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overflow,
  output logic                 zero,
  output logic                 nan,
  output logic                 precision_lost,
  output logic                 underflow
);

  localparam int W    = 1 + EXP_W + FRA_W;
  localparam int SW   = FRA_W + 1;
  localparam int PW   = 2 * SW;
  localparam int CW   = $clog2(SW);
  localparam int LW   = $clog2(PW);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int EMAX = (1 << EXP_W) - 1;

  typedef enum logic [1:0] {StIdle, StMul, StNorm, StDone} state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [PW-1:0]           mcand_q;
  logic [SW-1:0]           mplier_q;
  logic [PW-1:0]           acc_q;
  logic signed [EXP_W+1:0] exp_sum_q;
  logic                    sign_q;
  logic                    nan_q;
  logic                    inf_q;

  // Operand unpack
  logic [EXP_W-1:0] exp_a, exp_b, eff_a, eff_b;
  logic [FRA_W-1:0] fra_a, fra_b;
  logic             a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  logic signed [EXP_W+1:0] exp_sum_d;

  assign exp_a  = num1[W-2 -: EXP_W];
  assign exp_b  = num2[W-2 -: EXP_W];
  assign fra_a  = num1[FRA_W-1:0];
  assign fra_b  = num2[FRA_W-1:0];
  assign eff_a  = (exp_a == '0) ? EXP_W'(1) : exp_a;
  assign eff_b  = (exp_b == '0) ? EXP_W'(1) : exp_b;
  assign a_nan  = (&exp_a) && (|fra_a);
  assign a_inf  = (&exp_a) && !(|fra_a);
  assign a_zero = !(|exp_a) && !(|fra_a);
  assign b_nan  = (&exp_b) && (|fra_b);
  assign b_inf  = (&exp_b) && !(|fra_b);
  assign b_zero = !(|exp_b) && !(|fra_b);
  assign exp_sum_d = $signed({2'b00, eff_a}) + $signed({2'b00, eff_b})
                   - $signed((EXP_W + 2)'(BIAS));

  assign ready_o = (state_q == StIdle) && !rst;

  // Normalisation of the finished product
  logic [LW-1:0]      lead;
  logic signed [31:0] exp_n;
  logic signed [31:0] shift_n;
  logic [PW-1:0]      aligned;
  logic [2*PW-1:0]    ext;
  logic [FRA_W-1:0]   frac_n;
  logic               sticky, is_sub;
  logic [W-1:0]       res_n;
  logic               ovf_n, zero_n, nan_n, lost_n, unf_n;

  always_comb begin
    lead = '0;
    for (int i = 0; i < PW; i++) begin
      if (acc_q[i]) lead = LW'(i);
    end
    // Biased exponent of the product once its leading one sits at the hidden-bit position.
    exp_n   = 32'(exp_sum_q) + $signed(32'(lead)) - $signed(32'(2 * FRA_W));
    aligned = acc_q << (LW'(PW - 1) - lead);
    if (exp_n > 0)           shift_n = 0;
    else if (exp_n < 1 - PW) shift_n = PW;
    else                     shift_n = 1 - exp_n;
    ext    = {aligned, {PW{1'b0}}} >> shift_n;
    frac_n = ext[2*PW-2 -: FRA_W];
    sticky = |ext[2*PW-2-FRA_W:0];
    is_sub = !ext[2*PW-1];

    res_n  = {sign_q, (is_sub ? EXP_W'(0) : exp_n[EXP_W-1:0]), frac_n};
    ovf_n  = 1'b0;
    zero_n = 1'b0;
    nan_n  = 1'b0;
    lost_n = 1'b0;
    unf_n  = 1'b0;
    if (nan_q) begin
      res_n = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRA_W - 1){1'b0}}};
      nan_n = 1'b1;
    end else if (inf_q) begin
      res_n = {sign_q, {EXP_W{1'b1}}, {FRA_W{1'b0}}};
    end else if (acc_q == '0) begin
      res_n  = {sign_q, {(W - 1){1'b0}}};
      zero_n = 1'b1;
    end else if (exp_n >= EMAX) begin
      res_n = {sign_q, {EXP_W{1'b1}}, {FRA_W{1'b0}}};
      ovf_n = 1'b1;
    end else begin
      lost_n = sticky;
      unf_n  = sticky && is_sub;
      zero_n = is_sub && (frac_n == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      mcand_q        <= '0;
      mplier_q       <= '0;
      acc_q          <= '0;
      exp_sum_q      <= '0;
      sign_q         <= 1'b0;
      nan_q          <= 1'b0;
      inf_q          <= 1'b0;
      result         <= '0;
      valid_o        <= 1'b0;
      overflow       <= 1'b0;
      zero           <= 1'b0;
      nan            <= 1'b0;
      precision_lost <= 1'b0;
      underflow      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (valid_i) begin
            mcand_q   <= {{SW{1'b0}}, |exp_a, fra_a};
            mplier_q  <= {|exp_b, fra_b};
            acc_q     <= '0;
            cnt_q     <= '0;
            exp_sum_q <= exp_sum_d;
            sign_q    <= num1[W-1] ^ num2[W-1];
            nan_q     <= a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
            inf_q     <= a_inf || b_inf;
            state_q   <= StMul;
          end
        end
        StMul: begin
          if (mplier_q[0]) acc_q <= acc_q + mcand_q;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          cnt_q    <= cnt_q + CW'(1);
          if (cnt_q == CW'(FRA_W)) state_q <= StNorm;
        end
        StNorm: begin
          result         <= res_n;
          overflow       <= ovf_n;
          zero           <= zero_n;
          nan            <= nan_n;
          precision_lost <= lost_n;
          underflow      <= unf_n;
          valid_o        <= 1'b1;
          state_q        <= StDone;
        end
        StDone: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_float_multi_seq.sv
// Scoreboard bench for float_multi_seq: directed vectors, randomized operands against an
// arithmetic reference model, handshake/backpressure/reset checks and a wide-format instance.
module tb_float_multi_seq;

  localparam int EW = 5;
  localparam int FW = 10;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  flags;  // {overflow, zero, nan, precision_lost, underflow}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] num1 = '0, num2 = '0, result;
  logic        valid_i = 1'b0, ready_i = 1'b0;
  logic        ready_o, valid_o, overflow, zero, nan, precision_lost, underflow;
  logic [4:0]  flags;

  logic [31:0] num1w = '0, num2w = '0, resultw;
  logic        valid_iw = 1'b0, ready_iw = 1'b1;
  logic        ready_ow, valid_ow, ovfw, zerow, nanw, lostw, unfw;

  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  logic ready_force = 1'b1;
  logic vprev = 1'b0;
  exp_t exp_q[$];
  int   lat_q[$];
  int   mon_l;
  exp_t mon_e;

  assign flags = {overflow, zero, nan, precision_lost, underflow};

  float_multi_seq #(.EXP_W(EW), .FRA_W(FW)) dut (
    .clk(clk), .rst(rst), .num1(num1), .num2(num2), .valid_i(valid_i), .ready_o(ready_o),
    .result(result), .valid_o(valid_o), .ready_i(ready_i), .overflow(overflow), .zero(zero),
    .nan(nan), .precision_lost(precision_lost), .underflow(underflow)
  );

  float_multi_seq #(.EXP_W(8), .FRA_W(23)) dut_w (
    .clk(clk), .rst(rst), .num1(num1w), .num2(num2w), .valid_i(valid_iw), .ready_o(ready_ow),
    .result(resultw), .valid_o(valid_ow), .ready_i(ready_iw), .overflow(ovfw), .zero(zerow),
    .nan(nanw), .precision_lost(lostw), .underflow(unfw)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #2;
    ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] r, input logic [4:0] f);
    exp_t e;
    e.res = r;
    e.flags = f;
    return e;
  endfunction

  // Value model: result magnitude measured in units of the smallest subnormal.
  function automatic exp_t model(input int ew, input int fw, input logic [63:0] a,
                                 input logic [63:0] b);
    exp_t r;
    longint unsigned emax, fmask, ea, eb, fa, fb, ma, mb, p, f;
    int bias, xa, xb, m, k, t, e, s;
    logic sg, nan_a, nan_b, inf_a, inf_b, zer_a, zer_b;
    bit st;
    r = '0;
    emax  = (64'd1 << ew) - 1;
    fmask = (64'd1 << fw) - 1;
    bias  = (1 << (ew - 1)) - 1;
    sg    = a[ew+fw] ^ b[ew+fw];
    ea = (a >> fw) & emax;  fa = a & fmask;
    eb = (b >> fw) & emax;  fb = b & fmask;
    nan_a = (ea == emax) && (fa != 0);  inf_a = (ea == emax) && (fa == 0);
    nan_b = (eb == emax) && (fb != 0);  inf_b = (eb == emax) && (fb == 0);
    zer_a = (ea == 0) && (fa == 0);     zer_b = (eb == 0) && (fb == 0);
    if (nan_a || nan_b || (inf_a && zer_b) || (inf_b && zer_a)) begin
      r.res = (emax << fw) | (64'd1 << (fw - 1));
      r.flags = 5'b00100;
    end else if (inf_a || inf_b) begin
      r.res = (64'(sg) << (ew + fw)) | (emax << fw);
    end else if (zer_a || zer_b) begin
      r.res = 64'(sg) << (ew + fw);
      r.flags = 5'b01000;
    end else begin
      ma = ((ea == 0) ? 64'd0 : (64'd1 << fw)) | fa;
      mb = ((eb == 0) ? 64'd0 : (64'd1 << fw)) | fb;
      xa = (ea == 0) ? 1 : int'(ea);
      xb = (eb == 0) ? 1 : int'(eb);
      p  = ma * mb;
      m  = 0;
      for (int i = 0; i < 64; i++) if (p[i]) m = i;
      k = xa + xb - bias - fw - 1;
      t = m + k;
      if (t >= fw) begin
        e = t - fw + 1;
        if (e >= int'(emax)) begin
          r.res = (64'(sg) << (ew + fw)) | (emax << fw);
          r.flags = 5'b10000;
        end else begin
          s = m - fw;
          if (s >= 0) begin
            f  = (p >> s) & fmask;
            st = (p & ((64'd1 << s) - 1)) != 0;
          end else begin
            f  = (p << (-s)) & fmask;
            st = 1'b0;
          end
          r.res = (64'(sg) << (ew + fw)) | (64'(e) << fw) | f;
          r.flags = {3'b000, st, 1'b0};
        end
      end else begin
        if (k >= 0) begin
          f = p << k;  st = 1'b0;
        end else if (-k >= 64) begin
          f = 0;  st = 1'b1;
        end else begin
          f  = p >> (-k);
          st = (p & ((64'd1 << (-k)) - 1)) != 0;
        end
        r.res = (64'(sg) << (ew + fw)) | f;
        r.flags = {1'b0, (f == 0), 1'b0, st, st};
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 9))
      0: v[14:0]  = 15'h0000;
      1: v[14:10] = 5'h1f;
      2: v[14:10] = 5'h00;
      3: v[14:0]  = 15'h7c00;
      default: ;
    endcase
    return v;
  endfunction

  // Called and returns just after a rising edge.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push,
                       input exp_t e);
    int n;
    n = 0;
    while (!ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: got ready_o=0 expected 1 (cycle %0d)", cyc);
      return;
    end
    num1 = a;  num2 = b;  valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    num1 = 16'($urandom);
    num2 = 16'($urandom);
    if (push) begin
      exp_q.push_back(e);
      lat_q.push_back(cyc);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic issue_w(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int acc;
    num1w = a;  num2w = b;  valid_iw = 1'b1;
    @(posedge clk); #1;
    valid_iw = 1'b0;
    acc = cyc;
    do @(negedge clk); while (!valid_ow && (cyc - acc) < 60);
    chk("w_latency", 64'(cyc - acc), 64'd25);
    chk("w_result", {32'b0, resultw}, e.res);
    chk("w_flags", {59'b0, ovfw, zerow, nanw, lostw, unfw}, {59'b0, e.flags});
    @(posedge clk); #1;
  endtask

  // Monitor: latency on each valid_o rise, result/flags on each handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o && !vprev) begin
        if (lat_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid_o=1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_l = lat_q.pop_front();
          chk("latency", 64'(cyc - mon_l), 64'(FW + 2));
        end
      end
      if (valid_o && ready_i && exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("result", {48'b0, result}, mon_e.res);
        chk("flags", {59'b0, flags}, {59'b0, mon_e.flags});
      end
    end
    vprev = valid_o;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] a, b, hold_res;
    logic [4:0]  hold_flags;
    logic [31:0] wa, wb;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ready", {63'b0, ready_o}, 64'd0);
    chk("reset_outputs", {42'b0, valid_o, flags, result}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", {63'b0, ready_o}, 64'd1);
    @(posedge clk); #1;

    issue(16'h3E00, 16'h4000, 1'b1, mk(64'h4200, 5'b00000));
    issue(16'hC000, 16'h3800, 1'b1, mk(64'hBC00, 5'b00000));
    issue(16'h1234, 16'h9876, 1'b1, mk(64'h801B, 5'b00011));
    issue(16'h0001, 16'h0001, 1'b1, mk(64'h0000, 5'b01011));
    issue(16'h0200, 16'h5800, 1'b1, mk(64'h1C00, 5'b00000));
    issue(16'h7BFF, 16'h4000, 1'b1, mk(64'h7C00, 5'b10000));
    issue(16'h7C00, 16'h0000, 1'b1, mk(64'h7E00, 5'b00100));
    issue(16'hFC00, 16'h4000, 1'b1, mk(64'hFC00, 5'b00000));
    issue(16'h4A00, 16'h8000, 1'b1, mk(64'h8000, 5'b01000));

    // Idle returns FRA_W+3 edges after accept with ready_i held high.
    issue(16'h3C00, 16'h4000, 1'b1, mk(64'h4000, 5'b00000));
    n = 0;
    while (!ready_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_after_accept_cycles", 64'(n), 64'(FW + 3));

    // Backpressure: result frozen, no new accept while DONE.
    ready_force = 1'b0;
    issue(16'h4400, 16'h3A00, 1'b1, mk(64'h4200, 5'b00000));
    n = 0;
    while (!valid_o && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("hold_valid_seen", {63'b0, valid_o}, 64'd1);
    hold_res   = result;
    hold_flags = flags;
    for (int i = 0; i < 20; i++) begin
      valid_i = ~valid_i;
      num1 = 16'($urandom);
      @(negedge clk);
      chk("hold_stable", {41'b0, valid_o, ready_o, flags, result},
          {41'b0, 1'b1, 1'b0, hold_flags, hold_res});
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    ready_force = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_release", {63'b0, ready_o}, 64'd1);

    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a = rand_op();
      b = rand_op();
      issue(a, b, 1'b1, model(EW, FW, {48'b0, a}, {48'b0, b}));
    end
    @(posedge clk); #1;
    rand_ready = 1'b0;
    drain();

    // Reset during MUL: outputs clear and the aborted op never appears.
    issue(16'h4000, 16'h4000, 1'b1, mk(64'h4400, 5'b00000));
    drain();
    issue(16'h3800, 16'h3800, 1'b0, mk(64'h0, 5'b0));
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_midop_outputs", {41'b0, valid_o, ready_o, flags, result}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_midop_rst", {63'b0, ready_o}, 64'd1);
    repeat (30) @(posedge clk);
    #1;
    issue(16'h3C00, 16'h3C00, 1'b1, mk(64'h3C00, 5'b00000));
    drain();

    issue_w(32'h3FC00000, 32'h40000000, mk(64'h40400000, 5'b00000));
    for (int i = 0; i < 4; i++) begin
      wa = $urandom;
      wb = $urandom;
      issue_w(wa, wb, model(8, 23, {32'b0, wa}, {32'b0, wb}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
